// File: rtl/audio_i2s_tx.sv
// Philips I2S stereo transmitter clocked by the 256*fs audio master clock.
// An 8-bit frame counter derives BCLK/LRCLK; one pair is buffered ahead of the playing frame.
module audio_i2s_tx #(
  parameter int SAMPLE_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    locked,
  input  logic [SAMPLE_WIDTH-1:0] sample_left,
  input  logic [SAMPLE_WIDTH-1:0] sample_right,
  input  logic                    sample_valid,
  output logic                    sample_ready,
  output logic                    underrun,
  output logic                    i2s_bclk,
  output logic                    i2s_lrclk,
  output logic                    i2s_sdata
);

  // Handshake: a pair transfers on a clk edge where sample_valid && sample_ready;
  // upstream holds valid and data stable until then, and nothing is sampled while ready is low.

  logic                    lock_meta, lock_s;
  logic [7:0]              cnt, cnt_next;
  logic                    hold_full, hold_full_next;
  logic                    first_frame, first_frame_next;
  logic [SAMPLE_WIDTH-1:0] hold_l, hold_r, hold_l_next, hold_r_next;
  logic [SAMPLE_WIDTH-1:0] act_l, act_r, act_l_next, act_r_next;
  logic [SAMPLE_WIDTH-1:0] word_next;
  logic                    accept, underrun_next, sdata_next, ready_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= locked;
      lock_s    <= lock_meta;
    end
  end

  always_comb begin
    accept           = sample_valid && sample_ready;
    cnt_next         = cnt;
    hold_full_next   = hold_full;
    first_frame_next = first_frame;
    hold_l_next      = hold_l;
    hold_r_next      = hold_r;
    act_l_next       = act_l;
    act_r_next       = act_r;
    underrun_next    = 1'b0;
    if (!lock_s) begin
      // Lost lock behaves exactly like a reset; any buffered pair is dropped.
      cnt_next         = 8'd0;
      hold_full_next   = 1'b0;
      first_frame_next = 1'b1;
      hold_l_next      = '0;
      hold_r_next      = '0;
      act_l_next       = '0;
      act_r_next       = '0;
    end else begin
      cnt_next = cnt + 8'd1;
      if (cnt == 8'd255) begin
        if (hold_full) begin
          act_l_next     = hold_l;
          act_r_next     = hold_r;
          hold_full_next = 1'b0;
        end else begin
          act_l_next    = '0;
          act_r_next    = '0;
          underrun_next = !first_frame;
        end
        first_frame_next = 1'b0;
      end
      // Accept only happens with hold empty, so it never collides with the load above.
      if (accept) begin
        hold_l_next    = sample_left;
        hold_r_next    = sample_right;
        hold_full_next = 1'b1;
      end
    end

    word_next  = cnt_next[7] ? act_r_next : act_l_next;
    sdata_next = 1'b0;
    for (int i = 0; i < SAMPLE_WIDTH; i++) begin
      if (cnt_next[6:2] == 5'(SAMPLE_WIDTH - i)) sdata_next = word_next[i];
    end
    ready_next = lock_meta && !hold_full_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= 8'd0;
      hold_full    <= 1'b0;
      first_frame  <= 1'b1;
      hold_l       <= '0;
      hold_r       <= '0;
      act_l        <= '0;
      act_r        <= '0;
      sample_ready <= 1'b0;
      underrun     <= 1'b0;
      i2s_bclk     <= 1'b0;
      i2s_lrclk    <= 1'b0;
      i2s_sdata    <= 1'b0;
    end else begin
      cnt          <= cnt_next;
      hold_full    <= hold_full_next;
      first_frame  <= first_frame_next;
      hold_l       <= hold_l_next;
      hold_r       <= hold_r_next;
      act_l        <= act_l_next;
      act_r        <= act_r_next;
      sample_ready <= ready_next;
      underrun     <= underrun_next;
      i2s_bclk     <= cnt_next[1];
      i2s_lrclk    <= cnt_next[7];
      i2s_sdata    <= sdata_next;
    end
  end

endmodule
